ledr_pattern_sequencer: RTL and testbench

Avalon-MM controller that drives the 10-bit LED PIO slave through its s1 write port. It replays a CPU-loaded table of LED patterns at a programmable step interval, either as one pass or looping. The CPU configures it through a zero-wait-state Avalon-MM slave (cfg_*). The block is the sole master of the PIO's s1 port in the system.

---
 rtl/ledr_seq_pkg.sv | 28 ++
 rtl/ledr_seq_step_timer.sv | 38 +++
 rtl/ledr_pattern_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ledr_pattern_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledr_seq_pkg.sv
// Shared constants and types for the LED pattern sequencer: register map,
// control/status bit positions and the sequencer state encoding.
package ledr_seq_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_LENGTH = 3'd3;
  localparam logic [2:0] REG_PTR    = 3'd4;
  localparam logic [2:0] REG_DATA   = 3'd5;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_LOOP_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_IDX_LSB  = 8;

  // The PIO data register lives at offset 0 of its s1 port.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ledr_seq_step_timer.sv
// Step-interval down-counter: loaded during the ISSUE cycle, decremented in
// WAIT, and flags expiry when it reaches zero.
module ledr_seq_step_timer #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    dec,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    expired
);

  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2);
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE    = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] load_value;

  // The ISSUE cycle and the expiry cycle are both part of the step, so the
  // counter starts at eff_period-2; periods 0 and 1 behave as 2.
  assign load_value = (period < MIN_PERIOD) ? '0 : period - MIN_PERIOD;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ledr_pattern_sequencer.sv
// Avalon-MM master that replays a CPU-loaded LED pattern table into the PIO
// s1 port at a programmable step interval, one-shot or looping.
module ledr_pattern_sequencer
  import ledr_seq_pkg::*;
#(
  parameter int LED_WIDTH    = 10,
  parameter int DEPTH        = 16,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  localparam int IDXW = $clog2(DEPTH);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
  localparam logic [IDXW:0]   LEN_ONE = (IDXW + 1)'(1);
  localparam logic [IDXW:0]   LEN_MAX = (IDXW + 1)'(DEPTH);

  seq_state_e state;

  logic [IDXW-1:0]         idx;
  logic [IDXW-1:0]         ptr;
  logic                    run;
  logic                    loop;
  logic                    done;
  logic [PERIOD_WIDTH-1:0] period;
  logic [IDXW:0]           length;
  logic [LED_WIDTH-1:0]    pattern_table [DEPTH];

  logic            cfg_wr;
  logic            ctrl_wr;
  logic            status_wr;
  logic            start;
  logic            abort;
  logic            step_expired;
  logic            step_end;
  logic            more_steps;
  logic            issue;
  logic [IDXW-1:0] issue_idx;
  logic [IDXW:0]   eff_length;
  logic [IDXW:0]   idx_inc;

  assign cfg_wr    = cfg_chipselect && !cfg_write_n;
  assign ctrl_wr   = cfg_wr && (cfg_address == REG_CTRL);
  assign status_wr = cfg_wr && (cfg_address == REG_STATUS);

  // A CTRL write with RUN=0 always stops; RUN=1 only starts from IDLE.
  assign abort = ctrl_wr && !cfg_writedata[CTRL_RUN_BIT];
  assign start = ctrl_wr && cfg_writedata[CTRL_RUN_BIT] && (state == ST_IDLE) && (length != '0);

  assign eff_length = (length > LEN_MAX) ? LEN_MAX : length;
  assign idx_inc    = {1'b0, idx} + LEN_ONE;
  assign more_steps = (idx_inc < eff_length);
  assign step_end   = (state == ST_WAIT) && step_expired;

  // Abort has priority over both a fresh start and a step-end reissue.
  assign issue     = !abort && (start || (step_end && (more_steps || loop)));
  assign issue_idx = (start || !more_steps) ? '0 : idx + IDX_ONE;

  ledr_seq_step_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_step_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == ST_ISSUE),
    .dec     (state == ST_WAIT),
    .period  (period),
    .expired (step_expired)
  );

  // Configuration registers and the pattern table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
      length <= '0;
      ptr    <= '0;
      // NOTE: the table is a small flop array that must read back as zero
      // after reset, so it is cleared here rather than mapped to a RAM.
      for (int i = 0; i < DEPTH; i++) begin
        pattern_table[i] <= '0;
      end
    end else if (cfg_wr) begin
      case (cfg_address)
        REG_PERIOD: period <= cfg_writedata[PERIOD_WIDTH-1:0];
        REG_LENGTH: length <= cfg_writedata[IDXW:0];
        REG_PTR:    ptr    <= cfg_writedata[IDXW-1:0];
        REG_DATA: begin
          pattern_table[ptr] <= cfg_writedata[LED_WIDTH-1:0];
          ptr                <= ptr + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered PIO outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      run            <= 1'b0;
      loop           <= 1'b0;
      done           <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      pio_chipselect <= issue;
      pio_write_n    <= !issue;
      if (issue) begin
        idx           <= issue_idx;
        pio_writedata <= {{(32 - LED_WIDTH){1'b0}}, pattern_table[issue_idx]};
      end

      if (ctrl_wr) begin
        loop <= cfg_writedata[CTRL_LOOP_BIT];
      end
      if (status_wr && cfg_writedata[STAT_DONE_BIT]) begin
        done <= 1'b0;
      end

      if (abort) begin
        run   <= 1'b0;
        state <= ST_IDLE;
      end else if (start) begin
        run   <= 1'b1;
        done  <= 1'b0;
        state <= ST_ISSUE;
      end else begin
        case (state)
          ST_IDLE:  ;
          ST_ISSUE: state <= ST_WAIT;
          ST_WAIT: begin
            if (step_expired) begin
              if (issue) begin
                state <= ST_ISSUE;
              end else begin
                // Placed after the W1C so a coincident clear loses to the set.
                run   <= 1'b0;
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign pio_address = PIO_DATA_ADDR;

  // NOTE: every path through this block starts from a full default, so no
  // latch is inferred for unused bits or unmapped addresses.
  always_comb begin
    cfg_readdata = '0;
    case (cfg_address)
      REG_CTRL: begin
        cfg_readdata[CTRL_RUN_BIT]  = run;
        cfg_readdata[CTRL_LOOP_BIT] = loop;
      end
      REG_STATUS: begin
        cfg_readdata[STAT_BUSY_BIT]             = (state != ST_IDLE);
        cfg_readdata[STAT_DONE_BIT]             = done;
        cfg_readdata[STAT_IDX_LSB +: IDXW]      = idx;
      end
      REG_PERIOD: cfg_readdata[PERIOD_WIDTH-1:0] = period;
      REG_LENGTH: cfg_readdata[IDXW:0]           = length;
      REG_PTR:    cfg_readdata[IDXW-1:0]         = ptr;
      REG_DATA:   cfg_readdata[LED_WIDTH-1:0]    = pattern_table[ptr];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// Self-checking bench: directed scenarios plus randomized runs compared
// against a transaction-level model of the expected PIO write schedule.
module tb_ledr_pattern_sequencer;
  import ledr_seq_pkg::*;

  localparam int LW    = 10;
  localparam int DEPTH = 16;
  localparam int PW    = 24;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  cfg_address = '0;
  logic        cfg_chipselect = 1'b0;
  logic        cfg_write_n = 1'b1;
  logic [31:0] cfg_writedata = '0;
  logic [31:0] cfg_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  ledr_pattern_sequencer #(
    .LED_WIDTH(LW), .DEPTH(DEPTH), .PERIOD_WIDTH(PW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observed PIO writes with the cycle they were visible in.
  logic [31:0] act_d[$];
  int          act_c[$];
  logic [31:0] exp_d[$];
  int          exp_c[$];

  always @(negedge clk) begin
    if (reset_n && pio_chipselect && !pio_write_n) begin
      act_d.push_back(pio_writedata);
      act_c.push_back(cyc);
      check("pio_addr", 32'(pio_address), 32'h0);
    end
  end

  // Reference model of the programmer-visible state.
  logic [LW-1:0] tbl [DEPTH];
  int ptr_m, idx_m, period_m, length_m;
  bit done_m, loop_m;

  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    ptr_m = 0; idx_m = 0; period_m = 0; length_m = 0; done_m = 0; loop_m = 0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_address = a; cfg_writedata = d; cfg_chipselect = 1'b1; cfg_write_n = 1'b0;
    @(posedge clk);
    #1;
    cfg_chipselect = 1'b0; cfg_write_n = 1'b1;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    cfg_address = a; cfg_chipselect = 1'b1; cfg_write_n = 1'b1;
    #1;
    d = cfg_readdata;
    cfg_chipselect = 1'b0;
  endtask

  task automatic read_all_check(input string tag);
    logic [31:0] d;
    cfg_read(REG_CTRL, d);   check({tag, "_ctrl"}, d, 32'(loop_m) << 1);
    cfg_read(REG_STATUS, d); check({tag, "_status"}, d, (32'(idx_m) << 8) | (32'(done_m) << 1));
    cfg_read(REG_PERIOD, d); check({tag, "_period"}, d, 32'(period_m));
    cfg_read(REG_LENGTH, d); check({tag, "_length"}, d, 32'(length_m));
    cfg_read(REG_PTR, d);    check({tag, "_ptr"}, d, 32'(ptr_m));
    cfg_read(REG_DATA, d);   check({tag, "_data"}, d, 32'(tbl[ptr_m]));
    cfg_read(3'd6, d);       check({tag, "_addr6"}, d, 32'h0);
    cfg_read(3'd7, d);       check({tag, "_addr7"}, d, 32'h0);
  endtask

  task automatic clear_queues();
    act_d.delete(); act_c.delete(); exp_d.delete(); exp_c.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_n_writes"}, 32'(act_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < act_d.size(); i++) begin
      check({tag, "_wr_data"}, act_d[i], exp_d[i]);
      check({tag, "_wr_cycle"}, 32'(act_c[i]), 32'(exp_c[i]));
    end
  endtask

  // Watches STATUS.BUSY for n cycles and returns the last busy cycle (-1 if none).
  task automatic watch_busy(input int n, output int last_busy);
    last_busy = -1;
    cfg_address = REG_STATUS;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (cfg_readdata[STAT_BUSY_BIT]) last_busy = cyc;
    end
  endtask

  task automatic load_table_random();
    logic [31:0] v;
    int p0;
    v = $urandom;
    cfg_write(REG_PTR, v);
    p0 = int'(v % DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      cfg_write(REG_DATA, v);
      tbl[(p0 + i) % DEPTH] = v[LW-1:0];
    end
    ptr_m = p0;
  endtask

  // One run: program PERIOD/LENGTH, start, optionally abort after some cycles,
  // then compare the write schedule and register state with the model.
  task automatic run_case(input string tag, input int p, input int l, input bit lp, input int abort_after);
    int effp, effl, s, a, last_busy;
    effp = (p < 2) ? 2 : p;
    effl = (l > DEPTH) ? DEPTH : l;
    cfg_write(REG_PERIOD, 32'(p)); period_m = p;
    cfg_write(REG_LENGTH, 32'(l) | ($urandom & 32'hFFFF_FFE0)); length_m = l;
    cfg_write(REG_STATUS, 32'h2); done_m = 0;
    clear_queues();
    cfg_write(REG_CTRL, {30'b0, lp, 1'b1}); s = cyc; loop_m = lp;
    a = 0;
    if (abort_after > 0) begin
      repeat (abort_after - 1) @(posedge clk);
      cfg_write(REG_CTRL, 32'h0); a = cyc; loop_m = 0;
    end else begin
      watch_busy(effl * effp + 4, last_busy);
      check({tag, "_busy_last"}, 32'(last_busy), (l == 0) ? 32'hFFFF_FFFF : 32'(s + effl * effp - 1));
    end
    repeat (effp + 3) @(posedge clk);
    for (int k = 0; l != 0 && (lp || k < effl) && k < 4096; k++) begin
      int c;
      c = s + k * effp;
      if (a != 0 && c >= a) break;
      exp_d.push_back(32'(tbl[k % effl]));
      exp_c.push_back(c);
    end
    if (exp_d.size() > 0) idx_m = (exp_d.size() - 1) % effl;
    done_m = !lp && (l != 0) && (a == 0 || s + effl * effp < a);
    check_writes(tag);
    read_all_check(tag);
  endtask

  task automatic reset_mid(input string tag, input int wait_cycles);
    int s;
    cfg_write(REG_PERIOD, 32'd8);
    cfg_write(REG_LENGTH, 32'd4);
    cfg_write(REG_CTRL, 32'h1); s = cyc;
    repeat (wait_cycles) @(posedge clk);
    #2;
    check({tag, "_pre_cs"}, 32'(pio_chipselect), (wait_cycles == 0) ? 32'h1 : 32'h0);
    reset_n = 1'b0;
    #1;
    check({tag, "_cs"}, 32'(pio_chipselect), 32'h0);
    check({tag, "_wn"}, 32'(pio_write_n), 32'h1);
    check({tag, "_wd"}, pio_writedata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mdl_reset();
    clear_queues();
    read_all_check(tag);
    repeat (20) @(posedge clk);
    check({tag, "_post_writes"}, 32'(act_d.size()), 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, last_busy, p, l, effp, effl, ab;
    bit lp;
    logic [31:0] d;

    mdl_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_cs", 32'(pio_chipselect), 32'h0);
    check("rst_wn", 32'(pio_write_n), 32'h1);
    check("rst_wd", pio_writedata, 32'h0);
    check("rst_addr", 32'(pio_address), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    read_all_check("reset");

    // Basic one-shot pass.
    cfg_write(REG_PTR, 32'h0);
    cfg_write(REG_DATA, 32'h001); tbl[0] = 10'h001;
    cfg_write(REG_DATA, 32'h002); tbl[1] = 10'h002;
    cfg_write(REG_DATA, 32'h004); tbl[2] = 10'h004;
    ptr_m = 3;
    run_case("basic", 5, 3, 1'b0, 0);

    run_case("loop_stop", 3, 2, 1'b1, 10);

    run_case("clamp0", 0, 1, 1'b0, 0);
    cfg_write(REG_STATUS, 32'h2); done_m = 0;
    cfg_read(REG_STATUS, d); check("w1c_status", d, 32'h0);
    run_case("clamp1", 1, 1, 1'b0, 0);
    run_case("refuse", 5, 0, 1'b0, 0);

    load_table_random();
    run_case("len_sat", 2, 20, 1'b0, 0);

    // Mid-run LENGTH shrink and table rewrite during step 0.
    cfg_write(REG_PTR, 32'h0); ptr_m = 0;
    cfg_write(REG_DATA, 32'h011); tbl[0] = 10'h011;
    cfg_write(REG_DATA, 32'h022); tbl[1] = 10'h022;
    cfg_write(REG_DATA, 32'h044); tbl[2] = 10'h044;
    cfg_write(REG_DATA, 32'h088); tbl[3] = 10'h088;
    ptr_m = 4;
    cfg_write(REG_PERIOD, 32'd6); period_m = 6;
    cfg_write(REG_LENGTH, 32'd4);
    cfg_write(REG_STATUS, 32'h2); done_m = 0;
    clear_queues();
    cfg_write(REG_CTRL, 32'h1); s = cyc; loop_m = 0;
    cfg_write(REG_LENGTH, 32'd2); length_m = 2;
    cfg_write(REG_PTR, 32'd1);
    cfg_write(REG_DATA, 32'h3C3); tbl[1] = 10'h3C3; ptr_m = 2;
    watch_busy(16, last_busy);
    check("midrun_busy_last", 32'(last_busy), 32'(s + 11));
    exp_d.push_back(32'h011); exp_c.push_back(s);
    exp_d.push_back(32'h3C3); exp_c.push_back(s + 6);
    idx_m = 1; done_m = 1;
    check_writes("midrun");
    read_all_check("midrun");

    // PTR wrap after a DATA write at the last entry.
    cfg_write(REG_PTR, 32'd15);
    cfg_write(REG_DATA, 32'h155); tbl[15] = 10'h155; ptr_m = 0;
    read_all_check("ptr_wrap");

    for (int it = 0; it < 30; it++) begin
      load_table_random();
      p  = $urandom_range(0, 6);
      l  = $urandom_range(0, 20);
      lp = 1'($urandom_range(0, 1));
      effp = (p < 2) ? 2 : p;
      effl = (l > DEPTH) ? DEPTH : l;
      if (lp) ab = $urandom_range(1, effl * effp * 2 + 2);
      else if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, effl * effp + 2);
      else ab = 0;
      run_case("rand", p, l, lp, ab);
    end

    reset_mid("rst_wait", 3);
    reset_mid("rst_issue", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
